// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: control bundle between the instruction sequencer and the CPU datapath/memory port A.
interface cpu_ctrl_if;
    logic [15:0] mem_q;
    logic        flag_z;
    logic        flag_n;
    logic [15:0] reg_enable;
    logic [3:0]  mux_a_sel;
    logic [3:0]  mux_b_sel;
    logic        mux_c_sel;
    logic [15:0] alu_control;
    logic        flag_enable;
    logic        pc_enable;
    logic        pc_load;
    logic        pc_mux_sel;
    logic        ld_mux_sel;
    logic        mem_we;
    logic        halted;
    logic [2:0]  state_dbg;

    modport master (
        input  mem_q, flag_z, flag_n,
        output reg_enable, mux_a_sel, mux_b_sel, mux_c_sel, alu_control, flag_enable,
               pc_enable, pc_load, pc_mux_sel, ld_mux_sel, mem_we, halted, state_dbg
    );

    modport slave (
        output mem_q, flag_z, flag_n,
        input  reg_enable, mux_a_sel, mux_b_sel, mux_c_sel, alu_control, flag_enable,
               pc_enable, pc_load, pc_mux_sel, ld_mux_sel, mem_we, halted, state_dbg
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/load/store sequencer for the 16-bit CPU.
module cpu_control_fsm #(
    parameter logic [3:0] RTYPE_OP  = 4'h0,
    parameter logic [3:0] MEM_OP    = 4'h4,
    parameter logic [3:0] HALT_OP   = 4'hF,
    parameter logic [3:0] EXT_LOAD  = 4'h0,
    parameter logic [3:0] EXT_STOR  = 4'h4,
    parameter logic [3:0] EXT_JCOND = 4'hC
) (
    input  logic      clk,
    input  logic      reset,
    cpu_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, LD_ADDR = 3'd3,
        LD_WB = 3'd4, STORE = 3'd5, HALT = 3'd6, BAD = 3'd7
    } state_t;

    state_t      state, next;
    logic [15:0] ir;
    logic [3:0]  op, ext, rd, rs;
    logic        taken;

    assign op  = ir[15:12];
    assign rd  = ir[11:8];
    assign ext = ir[7:4];
    assign rs  = ir[3:0];
    assign taken = rd == 4'b0000 ? bus.flag_z :
                   rd == 4'b0001 ? !bus.flag_z :
                   rd == 4'b1100 ? bus.flag_n :
                   rd == 4'b1110;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ir    <= '0;
        end else begin
            state <= next;
            if (state == DECODE) ir <= bus.mem_q;
        end
    end

    always_comb begin
        next            = FETCH;
        bus.reg_enable  = '0;
        bus.mux_a_sel   = '0;
        bus.mux_b_sel   = '0;
        bus.mux_c_sel   = 1'b0;
        bus.alu_control = '0;
        bus.flag_enable = 1'b0;
        bus.pc_enable   = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_mux_sel  = 1'b0;
        bus.ld_mux_sel  = 1'b0;
        bus.mem_we      = 1'b0;
        bus.halted      = 1'b0;
        bus.state_dbg   = state;
        case (state)
            FETCH:  next = DECODE;
            DECODE: next = EXEC;
            EXEC: begin
                if (op == MEM_OP) begin
                    if (ext == EXT_LOAD) next = LD_ADDR;
                    else if (ext == EXT_STOR) next = STORE;
                    else if (ext == EXT_JCOND) begin
                        bus.mux_a_sel = rs;
                        bus.pc_load   = taken;
                        bus.pc_enable = !taken;
                    end else bus.pc_enable = 1'b1;
                end else if (op == HALT_OP) next = HALT;
                else begin
                    // R-type and immediate ALU ops differ only in the bus B / immediate select
                    bus.mux_a_sel   = rd;
                    bus.mux_b_sel   = op == RTYPE_OP ? rs : 4'h0;
                    bus.mux_c_sel   = op != RTYPE_OP;
                    bus.alu_control = ir;
                    bus.reg_enable  = 16'h1 << rd;
                    bus.flag_enable = 1'b1;
                    bus.pc_enable   = 1'b1;
                end
            end
            LD_ADDR: begin
                bus.mux_a_sel  = rs;
                bus.pc_mux_sel = 1'b1;
                next           = LD_WB;
            end
            LD_WB: begin
                bus.mux_a_sel  = rs;
                bus.pc_mux_sel = 1'b1;
                bus.ld_mux_sel = 1'b1;
                bus.reg_enable = 16'h1 << rd;
                bus.pc_enable  = 1'b1;
            end
            STORE: begin
                bus.mux_a_sel  = rs;
                bus.mux_b_sel  = rd;
                bus.pc_mux_sel = 1'b1;
                bus.mem_we     = 1'b1;
                bus.pc_enable  = 1'b1;
            end
            HALT: begin
                bus.halted = 1'b1;
                next       = HALT;
            end
            default: bus.state_dbg = state;
        endcase
        if (state == BAD) bus.state_dbg = 3'd0;
    end
endmodule
